mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//  Sits downstream of the register file: takes rs/rt read data as operands.
//  Produces HI/LO after a fixed multi-cycle latency and signals completion so
//  control can stall the pipeline.
//  Also services MTHI/MTLO; MFHI/MFLO read the HI/LO outputs directly.
// PARAMETERS
//  DATA_WIDTH  32  operand width; iteration count = DATA_WIDTH
// PORTS
//  Clock         in   1   system clock, all state on posedge
//  Reset_n       in   1   asynchronous active-low reset
//  Start         in   1   launch operation (sampled only in IDLE)
//  Op            in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  Operand_A     in   32  rs value (multiplicand / dividend)
//  Operand_B     in   32  rt value (multiplier / divisor)
//  Write_HI      in   1   MTHI strobe
//  Write_LO      in   1   MTLO strobe
//  Write_Data    in   32  MTHI/MTLO data
//  Busy          out  1   operation in progress
//  Done          out  1   one-cycle pulse: HI/LO just updated by an op
//  Div_By_Zero   out  1   set with Done when DIV/DIVU had Operand_B==0
//  HI            out  32  HI register
//  LO            out  32  LO register
// BEHAVIOUR
//  Reset: asynchronous, active-low, effective immediately, including mid-op.
//   - State goes to IDLE.
//   - HI, LO, Busy, Done, Div_By_Zero all go to 0; the in-flight op is discarded.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//  IDLE, edge N with Start=1:
//   - Latch Op, operand magnitudes and sign flags; iteration count = 0.
//   - Busy=1 from N+1.
//   - Signed ops use |A| and |B|; unsigned ops use A and B raw.
//  RUN, edges N+1..N+32: one iteration per edge.
//   - Multiply: shift-add on a 64-bit accumulator.
//   - Divide: restoring shift-subtract, 32-bit remainder / 32-bit quotient.
//   - After the 32nd iteration, go to FIX.
//  FIX, edge N+33: apply signs and write HI/LO.
//   - State goes to IDLE; Busy=0; Done=1 for exactly one cycle.
//   - Latency is 33 edges from the Start edge to HI/LO valid, for every op.
//  Sign rules:
//   - MULT: negate the 64-bit product when sign(A) != sign(B).
//   - DIV: negate the quotient when signs differ; the remainder takes the
//     dividend's sign.
//   - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
//  Results: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
//  Divide by zero: full latency still applies.
//   - HI = Operand_A as latched; LO = 0xFFFFFFFF; Div_By_Zero=1 with Done.
//   - Div_By_Zero clears at the next Start.
//  Start while Busy: ignored; no queueing.
//  Start in the Done cycle: accepted, since the FSM is already in IDLE.
//  Write_HI/Write_LO: honoured only in IDLE with Start=0.
//   - Ignored while Busy.
//   - If asserted in the same cycle as Start, Start wins and the write is dropped.
//   - Both strobes together write both registers; Done is not pulsed.
//  Operands are sampled only at the Start edge; later input changes have no
//   effect on the result.
// TESTING
//  1 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001.
//    Busy high 33 cycles; Done pulses once, 33 edges after Start.
//  2 MULT A=-3 B=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB.
//    MULT A=0x80000000 B=0x80000000 -> HI=0x40000000 LO=0.
//  3 DIV A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//    DIVU A=100 B=7 -> LO=14 HI=2.
//    DIV A=0x80000000 B=-1 -> LO=0x80000000 HI=0.
//  4 DIVU A=5 B=0 -> HI=5 LO=0xFFFFFFFF, Div_By_Zero=1 with Done.
//    A following MULTU 2*3 clears the flag; result HI=0 LO=6.
//  5 Start pulsed again at cycle 5 of a run with different operands -> ignored;
//    first result unchanged.
//    Write_LO=1 Data=0x1234 while Busy -> ignored.
//    Same write in IDLE -> LO=0x1234 next edge.
//  6 Reset_n low at cycle 10 of a DIV -> HI=LO=0, Busy=Done=0 immediately.
//    After release, a new MULTU 4*5 completes normally with LO=20.

Source files
------------

// File: rtl/mult_div_if.sv
// Operation and result bus of the iterative multiply/divide unit.
// The master drives the operation and the MTHI/MTLO strobes; the slave returns status and HI/LO.
interface mult_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] Operand_A;
  logic [DATA_WIDTH-1:0] Operand_B;
  logic                  Write_HI;
  logic                  Write_LO;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic                  Busy;
  logic                  Done;
  logic                  Div_By_Zero;
  logic [DATA_WIDTH-1:0] HI;
  logic [DATA_WIDTH-1:0] LO;

  modport master (
    output Start, Op, Operand_A, Operand_B, Write_HI, Write_LO, Write_Data,
    input  Busy, Done, Div_By_Zero, HI, LO
  );

  modport slave (
    input  Start, Op, Operand_A, Operand_B, Write_HI, Write_LO, Write_Data,
    output Busy, Done, Div_By_Zero, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; one bit per cycle on magnitudes,
// signs applied in a final FIX cycle, so every operation takes the same latency.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       Clock,
  input  logic       Reset_n,
  mult_div_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      op_reg, op_next;
  logic [W-1:0]    oper_reg, oper_next;
  logic [W-1:0]    a_raw_reg, a_raw_next;
  logic            neg_res_reg, neg_res_next;
  logic            neg_rem_reg, neg_rem_next;
  logic            zero_div_reg, zero_div_next;
  logic [2*W-1:0]  acc_reg, acc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [W-1:0]    hi_reg, hi_next;
  logic [W-1:0]    lo_reg, lo_next;
  logic            done_reg, done_next;
  logic            dbz_reg, dbz_next;

  logic            in_signed;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_step;
  logic [W:0]      div_shift;
  logic [W+1:0]    div_trial;
  logic [2*W-1:0]  div_step;
  logic [2*W-1:0]  prod_fixed;
  logic [W-1:0]    quo_fixed, rem_fixed;

  always_comb begin
    in_signed = ~bus.Op[0];
    a_mag = (in_signed && bus.Operand_A[W-1]) ? -bus.Operand_A : bus.Operand_A;
    b_mag = (in_signed && bus.Operand_B[W-1]) ? -bus.Operand_B : bus.Operand_B;

    // Multiply: accumulator is {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, oper_reg} : '0);
    mul_step = {mul_sum, acc_reg[W-1:1]};

    // Divide: accumulator is {remainder, dividend/quotient}; restoring subtract on a W+1 bit window.
    div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    div_trial = {1'b0, div_shift} - {2'b00, oper_reg};
    div_step  = div_trial[W+1] ? {div_shift[W-1:0], acc_reg[W-2:0], 1'b0}
                               : {div_trial[W-1:0], acc_reg[W-2:0], 1'b1};

    prod_fixed = neg_res_reg ? -acc_reg : acc_reg;
    quo_fixed  = neg_res_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
    rem_fixed  = neg_rem_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    oper_next     = oper_reg;
    a_raw_next    = a_raw_reg;
    neg_res_next  = neg_res_reg;
    neg_rem_next  = neg_rem_reg;
    zero_div_next = zero_div_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;
    dbz_next      = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          op_next       = bus.Op;
          a_raw_next    = bus.Operand_A;
          neg_res_next  = in_signed & (bus.Operand_A[W-1] ^ bus.Operand_B[W-1]);
          neg_rem_next  = in_signed & bus.Operand_A[W-1];
          zero_div_next = bus.Op[1] && (bus.Operand_B == '0);
          oper_next     = bus.Op[1] ? b_mag : a_mag;
          acc_next      = {{W{1'b0}}, (bus.Op[1] ? a_mag : b_mag)};
          count_next    = '0;
          dbz_next      = 1'b0;
          state_next    = RUN;
        end else begin
          if (bus.Write_HI) hi_next = bus.Write_Data;
          if (bus.Write_LO) lo_next = bus.Write_Data;
        end
      end
      RUN: begin
        acc_next   = op_reg[1] ? div_step : mul_step;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_ITER) state_next = FIX;
      end
      FIX: begin
        if (!op_reg[1]) begin
          hi_next = prod_fixed[2*W-1:W];
          lo_next = prod_fixed[W-1:0];
        end else if (zero_div_reg) begin
          hi_next = a_raw_reg;
          lo_next = '1;
        end else begin
          hi_next = rem_fixed;
          lo_next = quo_fixed;
        end
        dbz_next   = zero_div_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      oper_reg     <= '0;
      a_raw_reg    <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      zero_div_reg <= 1'b0;
      acc_reg      <= '0;
      count_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      dbz_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      oper_reg     <= oper_next;
      a_raw_reg    <= a_raw_next;
      neg_res_reg  <= neg_res_next;
      neg_rem_reg  <= neg_rem_next;
      zero_div_reg <= zero_div_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
      dbz_reg      <= dbz_next;
    end
  end

  assign bus.Busy        = (state_reg != IDLE);
  assign bus.Done        = done_reg;
  assign bus.Div_By_Zero = dbz_reg;
  assign bus.HI          = hi_reg;
  assign bus.LO          = lo_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected HI/LO into a scoreboard,
// a negedge monitor pops and compares on every Done pulse.
module tb_mult_div_unit;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 Clock = ~Clock;

  mult_div_if #(.DATA_WIDTH(32)) bus ();

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    if (Reset_n && bus.Done === 1'b1) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("result_HI", bus.HI, e.hi);
        check("result_LO", bus.LO, e.lo);
        check("result_DBZ", {31'd0, bus.Div_By_Zero}, {31'd0, e.dbz});
        $display("done: HI=0x%08h LO=0x%08h DBZ=%0b", bus.HI, bus.LO, bus.Div_By_Zero);
      end
    end
  end

  // Launch one op, track Busy and latency; optionally disturb the run with a Start and a Write_LO.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz,
                       input bit disturb);
    int busy_cnt;
    int lat;
    exp_t e;
    @(negedge Clock);
    bus.Op = op; bus.Operand_A = a; bus.Operand_B = b; bus.Start = 1'b1;
    e.hi = exp_hi; e.lo = exp_lo; e.dbz = exp_dbz;
    sb_q.push_back(e);
    $display("start: op=%0d A=0x%08h B=0x%08h expect HI=0x%08h LO=0x%08h", op, a, b, exp_hi, exp_lo);
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    bus.Operand_A = 32'hDEAD_BEEF; bus.Operand_B = 32'h0000_0003;
    check("dbz_clear_on_start", {31'd0, bus.Div_By_Zero}, 32'd0);
    busy_cnt = bus.Busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (disturb && k == 5) begin
        bus.Start = 1'b1; bus.Op = OP_DIV; bus.Operand_A = 32'h55; bus.Operand_B = 32'h2;
      end
      if (disturb && k == 6) begin
        bus.Start = 1'b0; bus.Write_LO = 1'b1; bus.Write_Data = 32'h1234;
      end
      if (disturb && k == 7) bus.Write_LO = 1'b0;
      @(posedge Clock); #1;
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 33);
    check("busy_cycles", busy_cnt, 33);
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = 2'b00; bus.Operand_A = '0; bus.Operand_B = '0;
    bus.Write_HI = 1'b0; bus.Write_LO = 1'b0; bus.Write_Data = '0;

    #2 Reset_n = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_HI", bus.HI, 32'd0);
    check("reset_LO", bus.LO, 32'd0);
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_done", {31'd0, bus.Done}, 32'd0);
    check("reset_dbz", {31'd0, bus.Div_By_Zero}, 32'd0);
    @(negedge Clock) Reset_n = 1'b1;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0);
    do_op(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 1'b0);
    do_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0, 1'b1);

    // MTLO in IDLE
    @(negedge Clock);
    bus.Write_LO = 1'b1; bus.Write_Data = 32'h1234;
    @(posedge Clock); #1;
    bus.Write_LO = 1'b0;
    check("mtlo_LO", bus.LO, 32'h1234);
    check("mtlo_HI_kept", bus.HI, 32'd1);
    check("mtlo_no_done", {31'd0, bus.Done}, 32'd0);
    $display("mtlo: LO=0x%08h HI=0x%08h", bus.LO, bus.HI);

    // MTHI+MTLO together
    @(negedge Clock);
    bus.Write_HI = 1'b1; bus.Write_LO = 1'b1; bus.Write_Data = 32'hA5A5_0F0F;
    @(posedge Clock); #1;
    bus.Write_HI = 1'b0; bus.Write_LO = 1'b0;
    check("mthilo_HI", bus.HI, 32'hA5A5_0F0F);
    check("mthilo_LO", bus.LO, 32'hA5A5_0F0F);
    $display("mthi+mtlo: HI=0x%08h LO=0x%08h", bus.HI, bus.LO);

    // Reset in the middle of a DIV (nothing pushed: the result must never appear)
    @(negedge Clock);
    bus.Op = OP_DIV; bus.Operand_A = 32'd100; bus.Operand_B = 32'd7; bus.Start = 1'b1;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    check("midop_reset_HI", bus.HI, 32'd0);
    check("midop_reset_LO", bus.LO, 32'd0);
    check("midop_reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("midop_reset_done", {31'd0, bus.Done}, 32'd0);
    $display("mid-op reset: HI=0x%08h LO=0x%08h Busy=%0b", bus.HI, bus.LO, bus.Busy);
    @(negedge Clock) Reset_n = 1'b1;

    do_op(OP_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 1'b0);

    repeat (3) @(posedge Clock);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past time limit");
    $fatal(1, "timeout");
  end
endmodule
